// File: rtl/id_operand_stage_pkg.sv
// Shared constants for the decode/operand stage and the ALU: widths, instruction
// field positions, opcode/func codes and small field-extract helpers.
package id_operand_stage_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int AW     = 5;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  function automatic logic [AW-1:0] get_rs(input logic [DATA_W-1:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [AW-1:0] get_rt(input logic [DATA_W-1:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/id_operand_stage_gpr_file.sv
// 32-entry GPR file: one write port, two combinational read ports with write-through
// bypass; latency 0 for reads, 1 edge for writes; no backpressure. Register 0 reads zero.
module gpr_file
  import id_operand_stage_pkg::*;
#(
  parameter int P_DATA_W = DATA_W,
  parameter int P_NREG   = NREG,
  parameter int P_AW     = AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wen,
  input  logic [P_AW-1:0]     i_waddr,
  input  logic [P_DATA_W-1:0] i_wdata,
  input  logic [P_AW-1:0]     i_raddr1,
  input  logic [P_AW-1:0]     i_raddr2,
  output logic [P_DATA_W-1:0] o_rdata1,
  output logic [P_DATA_W-1:0] o_rdata2
);

  logic [P_DATA_W-1:0] r_regs [P_NREG];
  logic                w_wr;

  assign w_wr = i_wen && (i_waddr != '0);

  // Entry 0 is never written, so the plain array read already returns zero for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < P_NREG; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (w_wr && (i_waddr == i_raddr1)) ? i_wdata : r_regs[i_raddr1];
  assign o_rdata2 = (w_wr && (i_waddr == i_raddr2)) ? i_wdata : r_regs[i_raddr2];

endmodule

// File: rtl/id_operand_stage.sv
// Decode/operand fetch: 1-cycle accept-to-valid single-entry register, 1 instr/clk.
// Backpressure: in_ready = !out_valid || out_ready; held operands track writeback while stalled.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int P_DATA_W = DATA_W,
  parameter int P_NREG   = NREG,
  parameter int P_AW     = AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [P_DATA_W-1:0] in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [P_DATA_W-1:0] out_instr,
  output logic [P_DATA_W-1:0] out_gr1,
  output logic [P_DATA_W-1:0] out_gr2,
  input  logic                wb_en,
  input  logic [P_AW-1:0]     wb_addr,
  input  logic [P_DATA_W-1:0] wb_data,
  output logic [15:0]         busy_cnt
);

  logic                r_out_valid;
  logic [P_DATA_W-1:0] r_out_instr;
  logic [P_DATA_W-1:0] r_out_gr1;
  logic [P_DATA_W-1:0] r_out_gr2;
  logic [15:0]         r_busy_cnt;

  logic                w_accept;
  logic [P_DATA_W-1:0] w_rd1;
  logic [P_DATA_W-1:0] w_rd2;
  logic [P_AW-1:0]     w_held_rs;
  logic [P_AW-1:0]     w_held_rt;
  logic                w_wb_live;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_held_rs = r_out_instr[RS_HI:RS_LO];
  assign w_held_rt = r_out_instr[RT_HI:RT_LO];
  assign w_wb_live = wb_en && (wb_addr != '0);

  gpr_file #(
    .P_DATA_W(P_DATA_W),
    .P_NREG  (P_NREG),
    .P_AW    (P_AW)
  ) u_gpr_file (
    .clk     (clk),
    .rst     (rst),
    .i_wen   (wb_en),
    .i_waddr (wb_addr),
    .i_wdata (wb_data),
    .i_raddr1(in_instr[RS_HI:RS_LO]),
    .i_raddr2(in_instr[RT_HI:RT_LO]),
    .o_rdata1(w_rd1),
    .o_rdata2(w_rd2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_gr1   <= '0;
      r_out_gr2   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_instr <= in_instr;
      r_out_gr1   <= w_rd1;
      r_out_gr2   <= w_rd2;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      // Held operands would otherwise go stale if their source register is rewritten.
      if (r_out_valid && w_wb_live && (wb_addr == w_held_rs)) r_out_gr1 <= wb_data;
      if (r_out_valid && w_wb_live && (wb_addr == w_held_rt)) r_out_gr2 <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_cnt <= '0;
    end else if (r_out_valid && !out_ready && (r_busy_cnt != 16'hFFFF)) begin
      r_busy_cnt <= r_busy_cnt + 16'd1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_gr1   = r_out_gr1;
  assign out_gr2   = r_out_gr2;
  assign busy_cnt  = r_busy_cnt;

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode/operand-fetch stage directly upstream of the ALU.
- Holds the 32x32 general-purpose register file. Accepts one 32-bit MIPS instruction per handshake and reads rs/rt.
- Presents the registered triple {instruction, gr1 = GPR[rs], gr2 = GPR[rt]} to the ALU's i_datain/gr1/gr2 inputs with valid/ready flow control.
- Accepts writeback from the downstream stage. Keeps operands coherent with writeback while stalled.

Parameters:
- DATA_W, 32, operand/instruction width
- NREG, 32, number of GPRs
- AW, 5, register address width (log2 NREG)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept instruction this cycle
- in_instr  in  DATA_W  instruction word
- out_valid  out  1  ALU triple valid
- out_ready  in  1  ALU/execute consumes triple this cycle
- out_instr  out  DATA_W  to ALU i_datain
- out_gr1  out  DATA_W  GPR[rs], to ALU gr1
- out_gr2  out  DATA_W  GPR[rt], to ALU gr2
- wb_en  in  1  writeback enable
- wb_addr  in  AW  writeback register index
- wb_data  in  DATA_W  writeback value
- busy_cnt  out  16  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset, synchronous on rising clk with rst=1:
  - all GPRs = 0
  - out_valid = 0; out_instr = out_gr1 = out_gr2 = 0; busy_cnt = 0
  - rst overrides every other input that cycle, including a pending handshake or writeback. Reset mid-stall discards the held entry.
- Field decode: rs = instr[25:21], rt = instr[20:16]. The stage performs no opcode interpretation. gr1/gr2 are always supplied; the ALU decides usage, e.g. sll ignores gr1.
- GPR0: reads always return 0. Writes to index 0 are ignored.
- GPR write: at the clk edge when wb_en=1 and wb_addr != 0.
- Reads are combinational from the file with write-through bypass. If wb_en=1 and wb_addr == rs (or rt), both non-zero, the read returns wb_data in that same cycle.
- Pipeline register, single entry:
  - in_ready = !out_valid || out_ready (combinational; no in_valid -> in_ready path).
  - Accept = in_valid && in_ready. On accept, at the edge: out_instr <= in_instr; out_gr1/out_gr2 <= bypassed reads; out_valid <= 1.
  - Latency: 1 cycle, input accept to out_valid.
  - out_valid && out_ready && !accept: out_valid <= 0 at the edge. Data outputs hold their last values.
  - Simultaneous drain and accept: the new entry replaces the old with no bubble. Sustained throughput is 1 instruction/clk.
- Stall coherence: while out_valid=1 and no new accept occurs, a writeback to the held entry's non-zero rs updates out_gr1 <= wb_data at the edge. Same rule for rt -> out_gr2. When rs == rt, both update.
- Outputs are stable while out_valid=1 and out_ready=0, except for the coherence update above.
- busy_cnt: increments each cycle with out_valid=1 && out_ready=0. Saturates at 16'hFFFF. Cleared only by rst.

Decomposition:
- Shared package (also used by the ALU bench), holding:
  - DATA_W, AW and NREG constants
  - instruction field positions: RS_HI=25, RS_LO=21, RT_HI=20, RT_LO=16
  - opcode/func localparams for the ALU instruction set
- One sub-module: gpr_file.
  - Contents: 32x32 array, sync reset clear, 1 write port, 2 combinational read ports with bypass, zero register.
  - The pipeline register, handshake, coherence logic and busy_cnt stay in id_operand_stage.

Test Plan:
1. Reset, then in_instr=32'h00011020 (add rs=0, rt=1) with GPR1 empty -> next cycle out_valid=1, out_gr1=0, out_gr2=0, out_instr=32'h00011020.
2. Load GPR1: wb_en=1, wb_addr=1, wb_data=32'hDDDDDDDD, with in_instr=32'h00011020 presented the same cycle -> out_gr2=32'hDDDDDDDD (bypass). Subsequent read also returns 32'hDDDDDDDD.
3. Write wb_addr=0, wb_data=32'hFFFFFFFF; then issue an instruction with rs=0 -> out_gr1=0.
4. Hold out_ready=0 for 3 cycles with valid held; meanwhile write GPR1=32'h40404040 -> out_gr2 updates to 32'h40404040. in_ready=0 throughout. busy_cnt=3. The new in_instr is not accepted until out_ready=1.
5. Back-to-back: out_ready=1, in_valid=1 for 4 consecutive instructions -> 4 consecutive out_valid cycles with no bubble, in order.
6. Assert rst while out_valid=1, out_ready=0 -> next cycle out_valid=0, outputs 0, busy_cnt=0, all GPR reads 0.
